pc_src_reg: RTL
===============

Name: pc_src_reg

Overview:
- Parametrised next-generation PC source selector with the PC register built in.
- Selects one of N_SRC candidate addresses (PC+4, ALUOut, jump target, EPC, exception vector, ...) and loads it into the PC.
- The load is unconditional or conditional on the branch result.
- Latches a sticky error on an out-of-range selector and keeps the previous PC for the control unit.
- Sits between the datapath candidate buses and the instruction-memory address port.

Parameters:
- DATA_W, 32, width of PC and of each candidate
- N_SRC, 5, number of candidate inputs (2..2**SEL_W)
- SEL_W, 3, selector width
- RESET_PC, 32'h0000_0000, PC value after reset
- EXC_VECTOR, 32'h0000_00FC, target loaded on rejected misaligned address (optional feature only)

Ports:
- clk, in, 1, rising-edge clock
- reset_n, in, 1, asynchronous active-low reset
- seletor, in, SEL_W, candidate index
- data_in, in, N_SRC*DATA_W, packed candidates; candidate k at bits [k*DATA_W +: DATA_W]
- pc_write, in, 1, unconditional load request
- pc_write_cond, in, 1, conditional load request
- cond_true, in, 1, branch condition from ALU
- err_clr, in, 1, clears sticky error flags
- pc_out, out, DATA_W, current PC (registered)
- pc_prev, out, DATA_W, PC value before the most recent load
- pc_updated, out, 1, one-cycle pulse after a load
- sel_err, out, 1, sticky: load attempted with seletor >= N_SRC
- err_sel, out, SEL_W, offending seletor of the first error since clear
- misalign_err, out, 1, sticky alignment error (0 when feature compiled out)

Behaviour:
- Reset (async, reset_n=0):
  - pc_out=RESET_PC, pc_prev=RESET_PC.
  - pc_updated=0, sel_err=0, err_sel=0, misalign_err=0.
  - Release is synchronous to the next clk edge; no load happens in the release cycle unless requested.
- load_req = pc_write | (pc_write_cond & cond_true). pc_write dominates; cond_true is ignored when pc_write=1.
- Valid load (load_req=1, seletor < N_SRC), at the edge:
  - pc_out <= candidate[seletor]
  - pc_prev <= old pc_out
  - pc_updated <= 1
  - Latency: 1 cycle from request to new pc_out.
- Invalid selector (load_req=1, seletor >= N_SRC):
  - pc_out and pc_prev hold; pc_updated <= 0.
  - sel_err <= 1.
  - err_sel <= seletor only if sel_err was 0 (first error retained).
  - Never drives X.
- No request: all registers hold; pc_updated <= 0.
- err_clr=1 clears sel_err, err_sel and misalign_err at the edge.
  - A simultaneous new error wins: the flag stays 1 and err_sel takes the new value.
- Selector values outside the candidate range are never decoded into data_in (no out-of-bounds slice).
- Loading the same value as the current PC still counts as a load: pc_prev updates and pc_updated pulses.
- Reset asserted mid-cycle overrides everything immediately.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN
- Defined: on a valid load, a selected candidate with bits [1:0] != 0 is rejected.
  - pc_out <= EXC_VECTOR, pc_prev <= old pc_out, pc_updated <= 1, misalign_err <= 1 (sticky, cleared by err_clr).
  - Selector-range check has priority over the alignment check.
- Undefined: no alignment check; misaligned targets load unchanged; misalign_err is tied to 0.

Test Plan:
- Reset, then pc_write=1, seletor=0, candidate0=32'h4 -> next cycle pc_out=32'h4, pc_prev=32'h0, pc_updated=1 for exactly one cycle.
- pc_write_cond=1, cond_true=0, seletor=1, candidate1=32'h100 -> pc_out unchanged, pc_updated=0. Repeat with cond_true=1 -> pc_out=32'h100.
- pc_write=1, seletor=3'b110 (N_SRC=5), pc_out=32'h100 -> pc_out stays 32'h100, sel_err=1, err_sel=3'b110. Then seletor=3'b111 -> err_sel stays 3'b110. err_clr=1 with no load -> sel_err=0, err_sel=0.
- Error and clear same cycle: err_clr=1 with pc_write=1, seletor=3'b101 -> sel_err=1, err_sel=3'b101.
- Assert reset_n=0 between clock edges during a load -> outputs return to reset values immediately without waiting for clk. Release -> no spurious pc_updated.
- With PC_ALIGN_CHECK_EN: pc_write=1, seletor=2, candidate2=32'h0000_0102 -> pc_out=32'h0000_00FC, misalign_err=1. Without the macro -> pc_out=32'h0000_0102, misalign_err=0.

Source files
------------

// File: rtl/pc_src_reg.sv
// Program-counter register with an N_SRC-way next-PC source selector, a sticky
// selector-range error, and (with PC_ALIGN_CHECK_EN defined) misaligned-target rejection.
module pc_src_reg #(
    parameter int              DATA_W     = 32,
    parameter int              N_SRC      = 5,
    parameter int              SEL_W      = 3,
    parameter logic [DATA_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_00FC
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SEL_W-1:0]        seletor,
    input  logic [N_SRC*DATA_W-1:0] data_in,
    input  logic                    pc_write,
    input  logic                    pc_write_cond,
    input  logic                    cond_true,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       pc_prev,
    output logic                    pc_updated,
    output logic                    sel_err,
    output logic [SEL_W-1:0]        err_sel,
    output logic                    misalign_err
);

    logic              load_req;
    logic              sel_ok;
    logic [31:0]       sel_ext;
    logic [DATA_W-1:0] cand;

    assign load_req = pc_write | (pc_write_cond & cond_true);
    assign sel_ext  = 32'(seletor);
    assign sel_ok   = (sel_ext < 32'(N_SRC));

    // Compare-and-pick mux: an out-of-range selector matches no slot and yields zero.
    always_comb begin
        cand = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (seletor == SEL_W'(k)) begin
                cand = data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out     <= RESET_PC;
            pc_prev    <= RESET_PC;
            pc_updated <= 1'b0;
        end else begin
            pc_updated <= 1'b0;
            if (load_req && sel_ok) begin
                pc_prev    <= pc_out;
                pc_updated <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                if (cand[1:0] != 2'b00) begin
                    pc_out <= EXC_VECTOR;
                end else begin
                    pc_out <= cand;
                end
`else
                pc_out <= cand;
`endif
            end
        end
    end

    // A new error in the same cycle as err_clr wins and records its selector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
            err_sel <= '0;
        end else if (load_req && !sel_ok) begin
            sel_err <= 1'b1;
            if (!sel_err || err_clr) begin
                err_sel <= seletor;
            end
        end else if (err_clr) begin
            sel_err <= 1'b0;
            err_sel <= '0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_err <= 1'b0;
        end else if (load_req && sel_ok && (cand[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end else if (err_clr) begin
            misalign_err <= 1'b0;
        end
    end
`else
    // EXC_VECTOR only matters when the alignment check is built in.
    assign misalign_err = 1'b0 & (^EXC_VECTOR);
`endif

endmodule
